// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : Fetch/decode/execute sequencer for a small bus machine.
//                It fetches one instruction byte at a time from memory over
//                the shared bus, then steps through decode, execute and
//                operand-fetch phases. Its outputs are one-hot strobes that
//                load bus registers from the bus and drive them onto the bus.
//                Encoding: op = ir[7:6], rd = ir[5:4], rs = ir[3:2].
//                  00 NOP, 01 MOV rd<-rs, 10 LDI rd<-next byte, 11 HLT
//  Revision    : 1.0  initial release
// ============================================================================
module control_sequencer #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] bus_in,
    output logic             fetch_req,
    input  logic             fetch_ack,
    output logic [WIDTH-1:0] pc,
    output logic [NREG-1:0]  reg_read_enable,
    output logic [NREG-1:0]  reg_write_enable,
    output logic             halted
);

    // ------------------------------------------------------------------------
    // Opcode encoding and increment constant
    // ------------------------------------------------------------------------
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_MOV = 2'b01;
    localparam logic [1:0] OP_LDI = 2'b10;
    localparam logic [1:0] OP_HLT = 2'b11;

    localparam logic [WIDTH-1:0] PC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXEC    = 3'd2,
        ST_OPERAND = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] ir;

    logic [1:0] op;
    logic [1:0] rd;
    logic [1:0] rs;

    // Decode only looks at ir[7:2]. Bits 1:0 and any bits above 7 are
    // ignored. This sink keeps the whole register visibly referenced.
    logic unused_ir_bits;

    assign op             = ir[7:6];
    assign rd             = ir[5:4];
    assign rs             = ir[3:2];
    assign unused_ir_bits = ^ir;

    // A memory handshake completes only in the two states that request one.
    // An ack seen in any other state has no effect.
    logic fetch_done;
    logic operand_done;

    assign fetch_done   = (state == ST_FETCH)   && fetch_ack;
    assign operand_done = (state == ST_OPERAND) && fetch_ack;

    // Convert a 2-bit register index into an NREG-wide one-hot strobe.
    // An index beyond NREG-1 gives no strobe.
    function automatic logic [NREG-1:0] index_to_onehot(input logic [1:0] idx);
        logic [NREG-1:0] vec;
        vec = '0;
        for (int i = 0; i < NREG; i++) begin
            if (int'(idx) == i) begin
                vec[i] = 1'b1;
            end
        end
        return vec;
    endfunction

    // State register. The FSM returns to FETCH asynchronously on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Program counter and instruction register.
    // These advance only on edges where a memory handshake completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= '0;
            ir <= '0;
        end else begin
            if (fetch_done || operand_done) begin
                pc <= pc + PC_ONE;
            end
            if (fetch_done) begin
                ir <= bus_in;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_FETCH: begin
                if (fetch_ack) begin
                    next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (op)
                    OP_NOP:  next_state = ST_FETCH;
                    OP_MOV:  next_state = ST_EXEC;
                    OP_LDI:  next_state = ST_OPERAND;
                    OP_HLT:  next_state = ST_HALT;
                    default: next_state = ST_FETCH;
                endcase
            end
            ST_EXEC: begin
                next_state = ST_FETCH;
            end
            ST_OPERAND: begin
                if (fetch_ack) begin
                    next_state = ST_FETCH;
                end
            end
            ST_HALT: begin
                next_state = ST_HALT;
            end
            default: begin
                next_state = ST_FETCH;
            end
        endcase
    end

    // Output decode.
    // Every output is gated by reset_n, so asserting reset silences the
    // strobes within the same cycle. A register load that is in flight when
    // reset hits therefore never completes.
    always_comb begin
        fetch_req        = 1'b0;
        reg_read_enable  = '0;
        reg_write_enable = '0;
        halted           = 1'b0;
        if (reset_n) begin
            case (state)
                ST_FETCH: begin
                    fetch_req = 1'b1;
                end
                ST_EXEC: begin
                    // Driving and loading the same register leaves it
                    // unchanged, so a self-move issues no strobes at all.
                    // This also keeps read and write off the same index.
                    if (rd != rs) begin
                        reg_write_enable = index_to_onehot(rs);
                        reg_read_enable  = index_to_onehot(rd);
                    end
                end
                ST_OPERAND: begin
                    fetch_req = 1'b1;
                    // Load the destination only while memory holds the
                    // operand byte valid on the bus.
                    if (fetch_ack) begin
                        reg_read_enable = index_to_onehot(rd);
                    end
                end
                ST_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    fetch_req = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
